fire4_expand3_bias_sched: RTL and testbench
===========================================

# fire4_expand3_bias_sched

Sequencer that applies per-channel bias to the fire4 expand3 convolution accumulator stream. It tracks output-channel group and pixel position, selects the matching bias words from the 128-entry constant bias bank, adds them lane-wise, rescales, saturates and (optionally) rectifies. It sits between the expand3 MAC array output and the fire4 concat/output buffer, with valid/ready flow control on both sides.

## Interface
- NUM_CH, 128: output channels; must equal bias bank depth and be a multiple of LANES
- LANES, 8: channels per stream beat
- PIXELS, 729: output pixels per frame (27x27)
- ACC_W, 32: accumulator/bias width, two's complement
- OUT_W, 16: output width, two's complement
- SHIFT, 8: arithmetic right shift applied after bias add

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one frame; honoured only in IDLE
- bias_mem  in  [ACC_W-1:0] x [0:NUM_CH-1]  constant bias bank
- in_valid  in  1  accumulator beat valid
- in_ready  out  1  accumulator beat accepted when in_valid&&in_ready
- in_data  in  LANES*ACC_W  lane l at bits [l*ACC_W +: ACC_W]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  LANES*OUT_W  lane l at bits [l*OUT_W +: OUT_W]
- out_last  out  1  final beat of frame, qualified by out_valid
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at frame completion

## Operation
- FSM: IDLE -> RUN on start; RUN -> DRAIN when last input beat accepted; DRAIN -> IDLE when last output beat handshakes (out_valid&&out_ready&&out_last).
- Beat order: channel-group-major within pixel; grp counts 0..NUM_CH/LANES-1 (0..15), then wraps to 0 and pix increments 0..PIXELS-1.
- Lane l of a beat uses bias_mem[grp*LANES+l].
- Per lane: sum = sext(acc,ACC_W+1) + sext(bias,ACC_W+1); scaled = sum >>> SHIFT; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- in_ready = (state==RUN) && (!out_valid || out_ready). No input accepted in IDLE or DRAIN.
- Input beat handshake loads output register; out_last set when grp==NUM_CH/LANES-1 and pix==PIXELS-1.
- start while busy: ignored. start coincident with rst: rst wins.
- done pulses the cycle after DRAIN->IDLE; busy drops that same cycle.

## Timing
- Reset values: state=IDLE, grp=0, pix=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, in_ready=0.
- Latency: accepted input beat appears on out_data the next cycle.
- Throughput: one beat per cycle with out_ready held high.
- Back-pressure: while out_valid&&!out_ready, out_data/out_last hold stable and in_ready=0.
- Simultaneous output handshake and new input handshake in one cycle: register reloads, out_valid stays 1.
- Counters wrap at frame end to 0; next frame needs a fresh start.
- rst mid-frame: returns to reset values next edge; partially delivered frame is abandoned, no done.
- busy rises the cycle after start is sampled in IDLE.

## Configuration
- FIRE4_EXPAND3_RELU_EN defined: saturated lane values below zero are forced to 0 (ReLU fused).
- Undefined: signed saturated values pass unchanged; no other behaviour differs.

## Test plan
- Single beat, grp0, all acc=0, bias[0..7]={-61,21,-60,266,135,-122,89,38}, SHIFT=0 -> out lanes {-61,21,-60,266,135,-122,89,38}; with RELU_EN negatives become 0.
- Saturation: acc=0x7FFFFFF0 + bias 266, SHIFT=8 -> lane = 32767; acc=0x80000000 + bias -61 -> -32768 (0 with RELU_EN).
- Full frame 729x16 beats, out_ready=1 -> 11664 outputs, out_last only on beat 11664, done one pulse, busy 0 afterwards; beat n uses bias group n mod 16.
- Random out_ready back-pressure (50%) -> no lost/duplicated beats, out_data stable while stalled, in_ready never high with a stalled full register.
- rst asserted at beat 500 -> next cycle out_valid=0, busy=0, grp=pix=0; new start processes full frame correctly from grp 0.
- start pulsed during RUN -> ignored; counters and beat count unchanged, single done.

Source files
------------

// File: rtl/fire4_expand3_bias_sched.sv
// Bias/rescale/saturate sequencer for the fire4 expand3 accumulator stream.
// Optional fused ReLU when FIRE4_EXPAND3_RELU_EN is defined.
module fire4_expand3_bias_sched #(
  parameter int unsigned NUM_CH = 128,
  parameter int unsigned LANES  = 8,
  parameter int unsigned PIXELS = 729,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ACC_W-1:0]       bias_mem [0:NUM_CH-1],
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned Groups = NUM_CH / LANES;
  localparam int unsigned GrpW   = (Groups > 1) ? $clog2(Groups) : 1;
  localparam int unsigned PixW   = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int unsigned IdxW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [GrpW-1:0]        grp_q;
  logic [PixW-1:0]        pix_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic [LANES*OUT_W-1:0] out_data_q;
  logic [LANES*OUT_W-1:0] next_data;
  logic                   done_q, done_d;
  logic                   in_fire, out_fire;
  logic                   last_grp, last_pix, last_beat;

  assign in_ready  = (state_q == StRun) && (!out_valid_q || out_ready);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign last_grp  = (grp_q == GrpW'(Groups - 1));
  assign last_pix  = (pix_q == PixW'(PIXELS - 1));
  assign last_beat = last_grp && last_pix;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

  // Per-lane datapath: widen by one bit so acc+bias can never wrap before the shift.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IdxW-1:0]         idx;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        bias;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W:0]   scaled;
    logic [OUT_W-1:0]        sat;

    assign idx    = IdxW'(grp_q * LANES + l);
    assign acc    = in_data[l*ACC_W +: ACC_W];
    assign bias   = bias_mem[idx];
    assign sum    = $signed({acc[ACC_W-1], acc}) + $signed({bias[ACC_W-1], bias});
    assign scaled = sum >>> SHIFT;

    always_comb begin
      // In range when every bit above the output sign bit matches the sign.
      if (scaled[ACC_W:OUT_W-1] == {(ACC_W - OUT_W + 2){scaled[ACC_W]}}) begin
        sat = scaled[OUT_W-1:0];
      end else if (scaled[ACC_W]) begin
        sat = {1'b1, {(OUT_W - 1){1'b0}}};
      end else begin
        sat = {1'b0, {(OUT_W - 1){1'b1}}};
      end
`ifdef FIRE4_EXPAND3_RELU_EN
      if (sat[OUT_W-1]) begin
        sat = '0;
      end
`endif
    end

    assign next_data[l*OUT_W +: OUT_W] = sat;
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (in_fire && last_beat) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_fire && out_last_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      grp_q       <= '0;
      pix_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (in_fire) begin
        out_data_q  <= next_data;
        out_last_q  <= last_beat;
        out_valid_q <= 1'b1;
        if (last_grp) begin
          grp_q <= '0;
          pix_q <= last_pix ? '0 : pix_q + PixW'(1);
        end else begin
          grp_q <= grp_q + GrpW'(1);
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fire4_expand3_bias_sched.sv
// Randomized bench for fire4_expand3_bias_sched against a queue-based reference model.
module tb_fire4_expand3_bias_sched;

  localparam int GROUPS = 16;
  localparam int TOTAL  = 729 * GROUPS;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [31:0]  bias [0:127];
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  fire4_expand3_bias_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bias_mem (bias),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           beat_in = 0;
  int           out_cnt = 0;
  int           done_cnt = 0;
  int           stall_cnt = 0;
  int           frame_id = 0;
  bit           bp = 0;
  bit           prev_stall = 0;
  logic [127:0] prev_data;
  logic         prev_last;
  logic [127:0] cap0, cap16;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: signed add, floor shift by 8, clamp to 16-bit range.
  function automatic logic [15:0] exp_lane(input logic [31:0] acc, input logic [31:0] b);
    longint s;
    s = longint'($signed(acc)) + longint'($signed(b));
    s = s >>> 8;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`ifdef FIRE4_EXPAND3_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[15:0];
  endfunction

  function automatic logic [127:0] model_beat(input logic [255:0] acc, input int n);
    logic [127:0] r;
    int g;
    g = n % GROUPS;
    for (int l = 0; l < 8; l++) r[l*16 +: 16] = exp_lane(acc[l*32 +: 32], bias[g*8 + l]);
    return r;
  endfunction

  function automatic logic [127:0] pack_lanes(input int v0, input int v1, input int v2,
                                               input int v3, input int v4, input int v5,
                                               input int v6, input int v7);
    int v [8];
    logic [127:0] r;
    v = '{v0, v1, v2, v3, v4, v5, v6, v7};
    for (int l = 0; l < 8; l++) r[l*16 +: 16] = 16'(v[l]);
    return r;
  endfunction

  function automatic logic [31:0] rand_acc();
    case ($urandom % 6)
      0:       return 32'h7FFF_FFF0;
      1:       return 32'h8000_0000;
      2, 3:    return $urandom;
      default: return 32'($urandom_range(0, 131071)) - 32'd65536;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {127'd0, out_valid}, 128'd1);
        chk("hold_data", out_data, prev_data);
        chk("hold_last", {127'd0, out_last}, {127'd0, prev_last});
      end
      if (out_valid && !out_ready) chk("in_ready_stalled", {127'd0, in_ready}, 128'd0);
      if (frame_id == 1 && busy && in_valid && !in_ready) stall_cnt++;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_output", 128'd1, 128'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", {127'd0, out_last}, {127'd0, e.last});
        end
        if (frame_id == 1 && out_cnt == 0) cap0 = out_data;
        if (frame_id == 1 && out_cnt == 16) cap16 = out_data;
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.data = model_beat(in_data, beat_in);
        e.last = (beat_in == TOTAL - 1);
        q.push_back(e);
        beat_in++;
      end
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp ? ($urandom % 2 == 1) : 1'b1;
    end
  end

  task automatic finish_sim();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=expired required=event", name);
    finish_sim();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_out_valid"}, {127'd0, out_valid}, 128'd0);
    chk({tag, "_out_data"}, out_data, 128'd0);
    chk({tag, "_out_last"}, {127'd0, out_last}, 128'd0);
    chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
    chk({tag, "_done"}, {127'd0, done}, 128'd0);
    chk({tag, "_in_ready"}, {127'd0, in_ready}, 128'd0);
  endtask

  task automatic run_frame(input int fid, input bit bpm, input bit gaps, input int rst_at,
                           input int start_at);
    int  dbefore;
    int  wd;
    bit  acc_now;
    frame_id  = fid;
    bp        = bpm;
    q.delete();
    beat_in   = 0;
    out_cnt   = 0;
    stall_cnt = 0;
    dbefore   = done_cnt;
    chk("busy_before_start", {127'd0, busy}, 128'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", {127'd0, busy}, 128'd1);
    for (int n = 0; n < TOTAL; n++) begin
      if (n == rst_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("mid_rst");
        chk("mid_rst_no_done", 128'(done_cnt), 128'(dbefore));
        q.delete();
        beat_in = 0;
        return;
      end
      if (gaps) begin
        while ($urandom % 4 == 0) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      for (int l = 0; l < 8; l++) in_data[l*32 +: 32] = rand_acc();
      if (fid == 1 && n == 0) in_data = '0;
      if (fid == 1 && n == 16) begin
        in_data = '0;
        in_data[31:0]   = 32'h8000_0000;
        in_data[127:96] = 32'h7FFF_FFF0;
      end
      if (n == start_at) start = 1'b1;
      wd = 0;
      forever begin
        @(negedge clk);
        acc_now = in_valid && in_ready;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (acc_now) break;
        wd++;
        if (wd > 1000) timeout("input_accept");
      end
    end
    in_valid = 1'b0;
    wd = 0;
    while (done_cnt == dbefore) begin
      @(posedge clk);
      #1;
      wd++;
      if (wd > 1000) timeout("done_wait");
    end
    repeat (3) @(posedge clk);
    #1;
    chk("frame_out_count", 128'(out_cnt), 128'(TOTAL));
    chk("frame_single_done", 128'(done_cnt), 128'(dbefore + 1));
    chk("frame_busy_after", {127'd0, busy}, 128'd0);
    chk("frame_queue_empty", 128'(q.size()), 128'd0);
    chk("frame_out_valid_after", {127'd0, out_valid}, 128'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 128; i++) begin
      case ($urandom % 4)
        0:       bias[i] = $urandom;
        1:       bias[i] = 32'($urandom_range(0, 400)) - 32'd200;
        default: bias[i] = 32'($urandom_range(0, 131071)) - 32'd65536;
      endcase
    end
    bias[0] = -32'sd61;  bias[1] = 32'sd21;   bias[2] = -32'sd60; bias[3] = 32'sd266;
    bias[4] = 32'sd135;  bias[5] = -32'sd122; bias[6] = 32'sd89;  bias[7] = 32'sd38;

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("in_rst");
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("post_rst");

    chk("model_sat_hi", 128'(exp_lane(32'h7FFF_FFF0, 32'd266)), 128'h7FFF);
    chk("model_small", 128'(exp_lane(32'd0, 32'd266)), 128'h0001);
`ifdef FIRE4_EXPAND3_RELU_EN
    chk("model_sat_lo", 128'(exp_lane(32'h8000_0000, -32'sd61)), 128'h0000);
    chk("model_neg", 128'(exp_lane(32'd0, -32'sd61)), 128'h0000);
`else
    chk("model_sat_lo", 128'(exp_lane(32'h8000_0000, -32'sd61)), 128'h8000);
    chk("model_neg", 128'(exp_lane(32'd0, -32'sd61)), 128'hFFFF);
`endif

    // Full frame at full rate, with a stray start mid-frame.
    run_frame(1, 1'b0, 1'b0, -1, 3000);
    chk("full_rate_no_stall", 128'(stall_cnt), 128'd0);
`ifdef FIRE4_EXPAND3_RELU_EN
    chk("beat0_lanes", cap0, pack_lanes(0, 0, 0, 1, 0, 0, 0, 0));
    chk("beat16_sat", cap16, pack_lanes(0, 0, 0, 32767, 0, 0, 0, 0));
`else
    chk("beat0_lanes", cap0, pack_lanes(-1, 0, -1, 1, 0, -1, 0, 0));
    chk("beat16_sat", cap16, pack_lanes(-32768, 0, -1, 32767, 0, -1, 0, 0));
`endif

    // Back-pressured frame abandoned by reset at beat 500.
    run_frame(2, 1'b1, 1'b1, 500, -1);
    repeat (2) @(posedge clk);
    #1;
    chk("after_abort_busy", {127'd0, busy}, 128'd0);

    // Fresh frame after abort, random stalls and gaps.
    run_frame(3, 1'b1, 1'b1, -1, -1);

    finish_sim();
  end

endmodule
